// File: rtl/f_arb_pkg.sv
// Shared types and helpers for the F permutation arbiter.
package f_arb_pkg;

  localparam int unsigned DsWidthDefault = 4;
  localparam int unsigned IWidthDefault  = 128;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StResp} state_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/f_arbiter_if.sv
// Requester-side and F-side signal bundle of the arbiter.
interface f_arbiter_if import f_arb_pkg::*; #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned CWIDTH  = 320,
  parameter int unsigned RWIDTH  = 32,
  parameter int unsigned XWIDTH  = 64,
  parameter int unsigned IWIDTH  = IWidthDefault,
  parameter int unsigned DSWIDTH = DsWidthDefault
);
  localparam int unsigned GW = clog2_min1(NREQ);

  logic [NREQ-1:0]         req;
  logic [NREQ*CWIDTH-1:0]  req_c;
  logic [NREQ*RWIDTH-1:0]  req_r;
  logic [NREQ*XWIDTH-1:0]  req_x;
  logic [NREQ*IWIDTH-1:0]  req_din;
  logic [NREQ*DSWIDTH-1:0] req_ds;
  logic [NREQ-1:0]         ack;
  logic                    err;
  logic [CWIDTH-1:0]       res_c;
  logic [RWIDTH-1:0]       res_r;
  logic [XWIDTH-1:0]       res_x;
  logic                    busy;
  logic [GW-1:0]           gnt_id;

  logic                    f_reset;
  logic [CWIDTH-1:0]       f_cin;
  logic [RWIDTH-1:0]       f_rin;
  logic [XWIDTH-1:0]       f_xin;
  logic [IWIDTH-1:0]       f_din;
  logic [DSWIDTH-1:0]      f_ds;
  logic [CWIDTH-1:0]       f_cout;
  logic [RWIDTH-1:0]       f_rout;
  logic [XWIDTH-1:0]       f_xout;
  logic                    f_done;

  modport slave (
    input  req, req_c, req_r, req_x, req_din, req_ds, f_cout, f_rout, f_xout, f_done,
    output ack, err, res_c, res_r, res_x, busy, gnt_id,
    output f_reset, f_cin, f_rin, f_xin, f_din, f_ds
  );

  modport master (
    output req, req_c, req_r, req_x, req_din, req_ds, f_cout, f_rout, f_xout, f_done,
    input  ack, err, res_c, res_r, res_x, busy, gnt_id,
    input  f_reset, f_cin, f_rin, f_xin, f_din, f_ds
  );

endinterface

// File: rtl/f_arbiter_rr_pick.sv
// Round-robin picker: first set request after ptr, wrapping modulo NREQ.
module rr_pick import f_arb_pkg::*; #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned GW  = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   ptr,
  output logic            found,
  output logic [GW-1:0]   idx
);

  logic [GW-1:0] k;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    k     = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      k = GW'((32'(ptr) + i) % NREQ);
      if (!found && req[k]) begin
        found = 1'b1;
        idx   = k;
      end
    end
  end

endmodule

// File: rtl/f_arbiter.sv
// Round-robin arbiter sharing one F permutation, with a RUN watchdog.
module f_arbiter import f_arb_pkg::*; #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned CWIDTH  = 320,
  parameter int unsigned RWIDTH  = 32,
  parameter int unsigned XWIDTH  = 64,
  parameter int unsigned IWIDTH  = IWidthDefault,
  parameter int unsigned DSWIDTH = DsWidthDefault,
  parameter int unsigned TIMEOUT = 1023
) (
  input logic        clk,
  input logic        reset,
  f_arbiter_if.slave bus
);

  localparam int unsigned GW = clog2_min1(NREQ);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [GW-1:0]       ptr_q, ptr_d, gnt_q, gnt_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CWIDTH-1:0]   cin_q, cin_d, resc_q, resc_d;
  logic [RWIDTH-1:0]   rin_q, rin_d, resr_q, resr_d;
  logic [XWIDTH-1:0]   xin_q, xin_d, resx_q, resx_d;
  logic [IWIDTH-1:0]   din_q, din_d;
  logic [DSWIDTH-1:0]  ds_q, ds_d;
  logic                err_q, err_d;
  logic                pick_found;
  logic [GW-1:0]       pick_idx;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    cin_d   = cin_q;
    rin_d   = rin_q;
    xin_d   = xin_q;
    din_d   = din_q;
    ds_d    = ds_q;
    resc_d  = resc_q;
    resr_d  = resr_q;
    resx_d  = resx_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          gnt_d   = pick_idx;
          cin_d   = bus.req_c[pick_idx*CWIDTH +: CWIDTH];
          rin_d   = bus.req_r[pick_idx*RWIDTH +: RWIDTH];
          xin_d   = bus.req_x[pick_idx*XWIDTH +: XWIDTH];
          din_d   = bus.req_din[pick_idx*IWIDTH +: IWIDTH];
          ds_d    = bus.req_ds[pick_idx*DSWIDTH +: DSWIDTH];
          state_d = StLoad;
        end
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        if (cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
        // f_done takes priority over a watchdog expiring in the same cycle.
        if (bus.f_done) begin
          resc_d  = bus.f_cout;
          resr_d  = bus.f_rout;
          resx_d  = bus.f_xout;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          resc_d  = '0;
          resr_d  = '0;
          resx_d  = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        ptr_d   = gnt_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= GW'(NREQ - 1);
      gnt_q   <= '0;
      cnt_q   <= '0;
      cin_q   <= '0;
      rin_q   <= '0;
      xin_q   <= '0;
      din_q   <= '0;
      ds_q    <= '0;
      resc_q  <= '0;
      resr_q  <= '0;
      resx_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      cin_q   <= cin_d;
      rin_q   <= rin_d;
      xin_q   <= xin_d;
      din_q   <= din_d;
      ds_q    <= ds_d;
      resc_q  <= resc_d;
      resr_q  <= resr_d;
      resx_q  <= resx_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy    = (state_q != StIdle);
  assign bus.f_reset = (state_q != StRun);
  assign bus.ack     = (state_q == StResp) ? (NREQ'(1) << gnt_q) : '0;
  assign bus.err     = err_q;
  assign bus.gnt_id  = gnt_q;
  assign bus.res_c   = resc_q;
  assign bus.res_r   = resr_q;
  assign bus.res_x   = resx_q;
  assign bus.f_cin   = cin_q;
  assign bus.f_rin   = rin_q;
  assign bus.f_xin   = xin_q;
  assign bus.f_din   = din_q;
  assign bus.f_ds    = ds_q;

endmodule

// File: tb/tb_f_arbiter.sv
// Directed bench for f_arbiter with a behavioural F model and a configurable done cycle.
module tb_f_arbiter;
  import f_arb_pkg::*;

  localparam int unsigned NREQ = 2, CW = 320, RW = 32, XW = 64, IW = 128, DW = 4, TMO = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  f_arbiter_if #(.NREQ(NREQ), .CWIDTH(CW), .RWIDTH(RW), .XWIDTH(XW), .IWIDTH(IW),
                 .DSWIDTH(DW)) bus ();

  f_arbiter #(.NREQ(NREQ), .CWIDTH(CW), .RWIDTH(RW), .XWIDTH(XW), .IWIDTH(IW),
              .DSWIDTH(DW), .TIMEOUT(TMO)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // F model: done after done_at cycles with f_reset low; simple invertible transforms.
  int run_cnt = 0;
  int done_at = 7;
  bit done_en = 1'b1;
  always @(posedge clk) begin
    if (bus.f_reset) run_cnt <= 0;
    else             run_cnt <= run_cnt + 1;
  end
  assign bus.f_done = done_en && !bus.f_reset && (run_cnt == done_at - 1);
  assign bus.f_cout = ~bus.f_cin;
  assign bus.f_rout = bus.f_rin + 32'h1;
  assign bus.f_xout = bus.f_xin ^ bus.f_din[63:0];

  int checks = 0;
  int failures = 0;

  logic [CW-1:0] c0 = {10{32'hA5A5_0001}};
  logic [CW-1:0] c1 = {10{32'h5A5A_0002}};
  logic [CW-1:0] c2 = {10{32'h0BAD_F00D}};
  logic [RW-1:0] r0 = 32'h0000_0010;
  logic [RW-1:0] r1 = 32'h1000_0000;
  logic [XW-1:0] x0 = 64'h0123_4567_89AB_CDEF;
  logic [XW-1:0] x1 = 64'hFEDC_BA98_7654_3210;
  logic [IW-1:0] d0 = {4{32'h0F0F_0F0F}};
  logic [IW-1:0] d1 = {4{32'h3333_CCCC}};

  task automatic set_slot(input int k, input logic [CW-1:0] c, input logic [RW-1:0] r,
                          input logic [XW-1:0] x, input logic [IW-1:0] d);
    bus.req_c[k*CW +: CW]   = c;
    bus.req_r[k*RW +: RW]   = r;
    bus.req_x[k*XW +: XW]   = x;
    bus.req_din[k*IW +: IW] = d;
    bus.req_ds[k*DW +: DW]  = DW'(k + 1);
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Counts edges until ack is seen, plus the cycles F was out of reset.
  task automatic wait_ack(input int limit, output bit seen, output int cycles, output int low);
    seen = 1'b0; cycles = 0; low = 0;
    while (!seen && cycles < limit) begin
      @(posedge clk);
      #1;
      cycles++;
      if (bus.f_reset === 1'b0) low++;
      if (bus.ack !== '0) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req = '0;
    bus.req_c = '0; bus.req_r = '0; bus.req_x = '0; bus.req_din = '0; bus.req_ds = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.ack !== 2'b00) begin failures++; $display("FAIL rst_ack: got %b want 00", bus.ack); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b want 0", bus.err); end
    checks++; if (bus.f_reset !== 1'b1) begin failures++; $display("FAIL rst_freset: got %b want 1", bus.f_reset); end
    checks++; if (bus.gnt_id !== 1'b0) begin failures++; $display("FAIL rst_gnt: got %b want 0", bus.gnt_id); end
    checks++; if (bus.res_c !== '0 || bus.f_cin !== '0) begin failures++; $display("FAIL rst_regs: res_c %h f_cin %h want 0", bus.res_c, bus.f_cin); end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    bit seen; int cyc, low;
    apply_reset();
    done_en = 1'b1; done_at = 7;
    set_slot(0, c0, r0, x0, d0);
    set_slot(1, c1, r1, x1, d1);
    bus.req = 2'b01;
    wait_ack(40, seen, cyc, low);
    checks++; if (!seen) begin failures++; $display("FAIL single_ack_seen: no ack in %0d cycles", cyc); end
    // ack appears in the 10th cycle counting the request cycle, i.e. 9 edges later.
    checks++; if (cyc != 9) begin failures++; $display("FAIL single_latency: got %0d edges want 9", cyc); end
    checks++; if (low != 7) begin failures++; $display("FAIL single_freset_low: got %0d want 7", low); end
    checks++; if (bus.ack !== 2'b01 || bus.err !== 1'b0) begin failures++; $display("FAIL single_ack: ack %b err %b want 01/0", bus.ack, bus.err); end
    checks++; if (bus.res_c !== ~c0) begin failures++; $display("FAIL single_res_c: got %h want %h", bus.res_c, ~c0); end
    checks++; if (bus.res_r !== r0 + 32'h1 || bus.res_x !== (x0 ^ d0[63:0])) begin failures++; $display("FAIL single_res_rx: got %h %h", bus.res_r, bus.res_x); end
    checks++; if (bus.f_ds !== 4'd1) begin failures++; $display("FAIL single_ds: got %h want 1", bus.f_ds); end
    bus.req = 2'b00;
    @(posedge clk);
    #1;
    checks++; if (bus.ack !== 2'b00 || bus.busy !== 1'b0) begin failures++; $display("FAIL single_after: ack %b busy %b want 00/0", bus.ack, bus.busy); end
  endtask

  task automatic test_contention();
    bit seen; int cyc, low;
    logic [1:0] want;
    int order_a[2] = '{0, 1};
    int order_b[4] = '{0, 1, 0, 1};
    apply_reset();
    done_en = 1'b1; done_at = 3;
    bus.req = 2'b11;
    for (int i = 0; i < 2; i++) begin
      wait_ack(30, seen, cyc, low);
      want = 2'(1 << order_a[i]);
      checks++; if (bus.ack !== want) begin failures++; $display("FAIL cont_a%0d: ack %b want %b", i, bus.ack, want); end
      checks++; if (bus.res_c !== ((order_a[i] == 0) ? ~c0 : ~c1)) begin failures++; $display("FAIL cont_a%0d_res: got %h", i, bus.res_c); end
      // Second grant: RESP, one IDLE, LOAD, 3 RUN cycles.
      if (i == 1) begin
        checks++; if (cyc != 6) begin failures++; $display("FAIL cont_gap: got %0d edges want 6", cyc); end
      end
      bus.req[order_a[i]] = 1'b0;
    end
    bus.req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_ack(30, seen, cyc, low);
      want = 2'(1 << order_b[i]);
      checks++; if (bus.ack !== want || bus.gnt_id !== 1'(order_b[i])) begin failures++; $display("FAIL cont_b%0d: ack %b gnt %0d want %b", i, bus.ack, bus.gnt_id, want); end
    end
    bus.req = 2'b00;
  endtask

  task automatic test_watchdog();
    bit seen; int cyc, low;
    apply_reset();
    done_en = 1'b0;
    bus.req = 2'b01;
    wait_ack(60, seen, cyc, low);
    checks++; if (!seen || cyc != 17) begin failures++; $display("FAIL wd_latency: seen %b got %0d edges want 17", seen, cyc); end
    checks++; if (low != 15) begin failures++; $display("FAIL wd_run_cycles: got %0d want 15", low); end
    checks++; if (bus.err !== 1'b1 || bus.ack !== 2'b01) begin failures++; $display("FAIL wd_err: err %b ack %b want 1/01", bus.err, bus.ack); end
    checks++; if (bus.res_c !== '0 || bus.res_r !== '0 || bus.res_x !== '0) begin failures++; $display("FAIL wd_res: %h %h %h want 0", bus.res_c, bus.res_r, bus.res_x); end
    bus.req = 2'b00;
    @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.err !== 1'b1) begin failures++; $display("FAIL wd_after: busy %b err %b want 0/1", bus.busy, bus.err); end
    done_en = 1'b1;
  endtask

  task automatic test_done_vs_timeout();
    bit seen; int cyc, low;
    apply_reset();
    done_en = 1'b1; done_at = 15;
    bus.req = 2'b10;
    wait_ack(60, seen, cyc, low);
    checks++; if (!seen || cyc != 17 || bus.ack !== 2'b10) begin failures++; $display("FAIL tie_ack: seen %b edges %0d ack %b", seen, cyc, bus.ack); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL tie_err: got %b want 0", bus.err); end
    checks++; if (bus.res_c !== ~c1 || bus.res_r !== r1 + 32'h1) begin failures++; $display("FAIL tie_res: got %h %h", bus.res_c, bus.res_r); end
    bus.req = 2'b00;
  endtask

  task automatic test_reset_mid_run();
    bit seen; int cyc, low;
    bit stray;
    apply_reset();
    done_en = 1'b1; done_at = 5;
    bus.req = 2'b01;
    wait_ack(30, seen, cyc, low);
    bus.req = 2'b10;
    low = 0;
    for (int i = 0; i < 20 && low < 3; i++) begin
      @(posedge clk);
      #1;
      if (bus.f_reset === 1'b0) low++;
    end
    checks++; if (low != 3) begin failures++; $display("FAIL mid_reach_run: got %0d run cycles want 3", low); end
    reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.f_reset !== 1'b1) begin failures++; $display("FAIL mid_immediate: busy %b f_reset %b want 0/1", bus.busy, bus.f_reset); end
    stray = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (bus.ack !== 2'b00) stray = 1'b1;
    end
    checks++; if (stray) begin failures++; $display("FAIL mid_no_ack: ack seen %b want none", stray); end
    reset = 1'b0;
    // Pointer is back at NREQ-1, so requester 0 wins.
    bus.req = 2'b11;
    wait_ack(30, seen, cyc, low);
    checks++; if (!seen || bus.ack !== 2'b01) begin failures++; $display("FAIL mid_next_grant: ack %b want 01", bus.ack); end
    checks++; if (bus.err !== 1'b0 || bus.res_c !== ~c0) begin failures++; $display("FAIL mid_next_res: err %b res_c %h", bus.err, bus.res_c); end
    bus.req = 2'b00;
  endtask

  task automatic test_operand_stability();
    bit seen; int cyc, low;
    apply_reset();
    done_en = 1'b1; done_at = 4;
    set_slot(0, c2, r0, x0, d0);
    bus.req = 2'b01;
    @(posedge clk);
    #1;
    bus.req_c[0 +: CW] = c1;
    bus.req = 2'b00;
    wait_ack(30, seen, cyc, low);
    checks++; if (!seen || bus.ack !== 2'b01) begin failures++; $display("FAIL stab_ack: seen %b ack %b want 01", seen, bus.ack); end
    checks++; if (bus.res_c !== ~c2 || bus.f_cin !== c2) begin failures++; $display("FAIL stab_res_c: res_c %h f_cin %h want %h", bus.res_c, bus.f_cin, ~c2); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_watchdog();
    test_done_vs_timeout();
    test_reset_mid_run();
    test_operand_stability();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
